// File: rtl/lcd_scene_scheduler.sv
// Frame-synchronous scene sequencer for the LCD renderer: detects frame wrap from the
// scanned y coordinate, picks the active scene and animates a bouncing sprite once per frame.
module lcd_scene_scheduler #(
    parameter int SCREEN_W    = 480,
    parameter int SCREEN_H    = 272,
    parameter int BORDER      = 4,
    parameter int SPRITE_W    = 32,
    parameter int SPRITE_H    = 32,
    parameter int STEP        = 2,
    parameter int AUTO_FRAMES = 300
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [8:0]  x,
    input  logic [8:0]  y,
    input  logic        key_next,
    input  logic        key_pause,
    input  logic        auto_en,
    output logic        frame_start,
    output logic [1:0]  scene,
    output logic [8:0]  sprite_x,
    output logic [8:0]  sprite_y,
    output logic [15:0] frame_count,
    output logic [7:0]  status_led
);

    localparam int TW = $clog2(AUTO_FRAMES);
    localparam logic [TW-1:0] T_LAST = TW'(AUTO_FRAMES - 1);
    localparam logic [9:0] X_MAX  = 10'(SCREEN_W - BORDER - SPRITE_W);
    localparam logic [9:0] Y_MAX  = 10'(SCREEN_H - BORDER - SPRITE_H);
    localparam logic [9:0] P_MIN  = 10'(BORDER);
    localparam logic [9:0] STEP10 = 10'(STEP);

    typedef enum logic [1:0] {
        S_HELLO  = 2'd0,
        S_BOUNCE = 2'd1,
        S_BARS   = 2'd2
    } scene_e;

    // The x coordinate is not needed: frame boundaries come from y alone.
    logic unused_x;
    assign unused_x = ^x;

    logic          kn_s1_q, kn_s2_q, kn_prev_q;
    logic          kp_s1_q, kp_s2_q;
    logic [8:0]    y_prev_q;
    logic          fs_q;

    scene_e        scene_q, scene_d;
    logic          pending_q, pending_d;
    logic          paused_q, paused_d;
    logic          auto_q, auto_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [8:0]    sx_q, sx_d, sy_q, sy_d;
    logic          dx_q, dx_d, dy_q, dy_d;
    logic [15:0]   fc_q, fc_d;

    logic          key_edge, wrap, advance;
    logic [10:0]   ax, ay;

    // Returns {dir, pos}; a move past a bound clamps to the bound and reverses direction.
    function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic dir,
                                              input logic [9:0] hi);
        logic [9:0] nxt;
        if (dir) begin
            nxt = pos + STEP10;
            if (nxt > hi) return {1'b0, hi};
            return {1'b1, nxt};
        end
        if (pos < P_MIN + STEP10) return {1'b1, P_MIN};
        nxt = pos - STEP10;
        return {1'b0, nxt};
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            kn_s1_q   <= 1'b0;
            kn_s2_q   <= 1'b0;
            kn_prev_q <= 1'b0;
            kp_s1_q   <= 1'b0;
            kp_s2_q   <= 1'b0;
            y_prev_q  <= '0;
            fs_q      <= 1'b0;
        end else begin
            kn_s1_q   <= key_next;
            kn_s2_q   <= kn_s1_q;
            kn_prev_q <= kn_s2_q;
            kp_s1_q   <= key_pause;
            kp_s2_q   <= kp_s1_q;
            y_prev_q  <= y;
            fs_q      <= wrap;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scene_q   <= S_HELLO;
            pending_q <= 1'b0;
            paused_q  <= 1'b0;
            auto_q    <= 1'b0;
            timer_q   <= '0;
            sx_q      <= 9'(BORDER);
            sy_q      <= 9'(BORDER);
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
            fc_q      <= '0;
        end else begin
            scene_q   <= scene_d;
            pending_q <= pending_d;
            paused_q  <= paused_d;
            auto_q    <= auto_d;
            timer_q   <= timer_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            fc_q      <= fc_d;
        end
    end

    always_comb begin
        key_edge  = kn_s2_q & ~kn_prev_q;
        wrap      = (y < y_prev_q);
        // A press landing on the frame_start cycle itself is folded into this advance.
        advance   = pending_q | key_edge | (auto_en & ~kp_s2_q & (timer_q == T_LAST));
        ax        = step_axis({1'b0, sx_q}, dx_q, X_MAX);
        ay        = step_axis({1'b0, sy_q}, dy_q, Y_MAX);

        scene_d   = scene_q;
        pending_d = pending_q | key_edge;
        paused_d  = paused_q;
        auto_d    = auto_q;
        timer_d   = timer_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        fc_d      = fc_q;

        if (fs_q) begin
            fc_d     = fc_q + 16'd1;
            paused_d = kp_s2_q;
            auto_d   = auto_en;
            if (advance) begin
                case (scene_q)
                    S_HELLO:  scene_d = S_BOUNCE;
                    S_BOUNCE: scene_d = S_BARS;
                    default:  scene_d = S_HELLO;
                endcase
                timer_d   = '0;
                pending_d = 1'b0;
            end else if (auto_en && !kp_s2_q) begin
                timer_d = timer_q + 1'b1;
            end
            // Motion follows the scene that was on screen for the frame just finished.
            if (scene_q == S_BOUNCE && !kp_s2_q) begin
                dx_d = ax[10];
                sx_d = ax[8:0];
                dy_d = ay[10];
                sy_d = ay[8:0];
            end
        end
    end

    assign frame_start = fs_q;
    assign scene       = scene_q;
    assign sprite_x    = sx_q;
    assign sprite_y    = sy_q;
    assign frame_count = fc_q;
    assign status_led  = {2'b00, dy_q, dx_q, auto_q, paused_q, scene_q};

endmodule

// File: tb/tb_lcd_scene_scheduler.sv
// Bench for lcd_scene_scheduler: compressed frame scans, a per-frame scoreboard model,
// a table of scene-sequencing vectors and directed bounce/pause/reset sequences.
module tb_lcd_scene_scheduler;

    localparam int AF = 4;
    localparam int FL = 24;

    logic        clock = 1'b0;
    logic        reset;
    logic [8:0]  x, y;
    logic        key_next, key_pause, auto_en;
    logic        frame_start;
    logic [1:0]  scene;
    logic [8:0]  sprite_x, sprite_y;
    logic [15:0] frame_count;
    logic [7:0]  status_led;

    always #5 clock = ~clock;

    lcd_scene_scheduler #(.AUTO_FRAMES(AF)) dut (
        .clock(clock), .reset(reset), .x(x), .y(y),
        .key_next(key_next), .key_pause(key_pause), .auto_en(auto_en),
        .frame_start(frame_start), .scene(scene), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .frame_count(frame_count), .status_led(status_led)
    );

    typedef struct { int scene; int sx; int sy; int fc; int led; int wrap_cyc; } exp_t;
    typedef struct { bit auto_on; bit pause; int presses; int exp_scene; } vec_t;

    exp_t exp_q[$];
    vec_t vecs[25];

    int n_checks = 0, n_fail = 0, n_pulses = 0, cyc = 0;
    int m_scene, m_sx, m_sy, m_dx, m_dy, m_fc, m_timer, m_pending, m_paused, m_auto, prev_y_m;
    int snap_scene, snap_sx, snap_sy, snap_fc;
    logic [7:0] snap_led;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic model_reset();
        m_scene = 0; m_sx = 4; m_sy = 4; m_dx = 1; m_dy = 1; m_fc = 0;
        m_timer = 0; m_pending = 0; m_paused = 0; m_auto = 0; prev_y_m = 0;
        exp_q.delete();
    endtask

    // Model of one frame_start update, using the control input levels held through the last frame.
    task automatic model_wrap();
        exp_t e;
        bit adv;
        adv = (m_pending != 0) || (auto_en && !key_pause && m_timer == AF - 1);
        if (m_scene == 1 && !key_pause) begin
            if (m_dx != 0) begin
                if (m_sx + 2 > 444) begin m_sx = 444; m_dx = 0; end else m_sx += 2;
            end else begin
                if (m_sx - 2 < 4) begin m_sx = 4; m_dx = 1; end else m_sx -= 2;
            end
            if (m_dy != 0) begin
                if (m_sy + 2 > 236) begin m_sy = 236; m_dy = 0; end else m_sy += 2;
            end else begin
                if (m_sy - 2 < 4) begin m_sy = 4; m_dy = 1; end else m_sy -= 2;
            end
        end
        m_fc = (m_fc + 1) % 65536;
        if (adv) begin
            m_scene = (m_scene == 2) ? 0 : m_scene + 1;
            m_timer = 0;
            m_pending = 0;
        end else if (auto_en && !key_pause) begin
            m_timer++;
        end
        m_paused = key_pause;
        m_auto = auto_en;
        e.scene = m_scene; e.sx = m_sx; e.sy = m_sy; e.fc = m_fc;
        e.led = m_dy * 32 + m_dx * 16 + m_auto * 8 + m_paused * 4 + m_scene;
        e.wrap_cyc = cyc;
        exp_q.push_back(e);
    endtask

    // Scans y = first..len-1, one line per cycle. auto_en/key_pause change at line first+2
    // (after the frame_start update), key presses start at line first+4.
    task automatic run_frame(input int first, input int len, input bit a, input bit p,
                             input int npress);
        for (int i = first; i < len; i++) begin
            @(posedge clock); #1;
            if (i < prev_y_m) model_wrap();
            y = 9'(i);
            x = (x == 9'd479) ? 9'd0 : x + 9'd1;
            prev_y_m = i;
            if (i == first + 2) begin auto_en = a; key_pause = p; end
            if (i == first + 3) begin
                snap_scene = scene; snap_sx = sprite_x; snap_sy = sprite_y;
                snap_fc = frame_count; snap_led = status_led;
            end
            if (i >= first + 4 && i < first + 4 + 4 * npress) begin
                key_next = ((i - first - 4) % 4) < 2;
                if ((i - first - 4) % 4 == 0) m_pending = 1;
            end else begin
                key_next = 1'b0;
            end
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_scene"}, scene, 0);
        chk({tag, "_sprite_x"}, sprite_x, 4);
        chk({tag, "_sprite_y"}, sprite_y, 4);
        chk({tag, "_frame_count"}, frame_count, 0);
        chk({tag, "_status_led"}, status_led, 8'h30);
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: each frame_start pulse pops one expected record; state is compared the
    // cycle after the pulse, once the frame update has landed.
    bit cmp_due = 0;
    int pulse_cyc = 0;
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (cmp_due) begin
            cmp_due = 0;
            chk("pulse_width", frame_start, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pulse_timing", pulse_cyc, e.wrap_cyc + 1);
                chk("sb_scene", scene, e.scene);
                chk("sb_sprite_x", sprite_x, e.sx);
                chk("sb_sprite_y", sprite_y, e.sy);
                chk("sb_frame_count", frame_count, e.fc);
                chk("sb_status_led", status_led, e.led);
                $display("frame %0d: scene=%0d sprite=(%0d,%0d) led=%02h", frame_count, scene,
                         sprite_x, sprite_y, status_led);
            end
        end
        if (frame_start) begin
            cmp_due = 1;
            pulse_cyc = cyc;
            n_pulses++;
        end
    end

    initial begin
        int guard, held_sx, held_dx, held_fc, base_pulses;

        vecs = '{
            '{1'b1, 1'b0, 0, 0}, '{1'b1, 1'b0, 0, 0}, '{1'b1, 1'b0, 0, 0}, '{1'b1, 1'b0, 0, 0},
            '{1'b1, 1'b0, 0, 1}, '{1'b1, 1'b0, 0, 1}, '{1'b1, 1'b0, 0, 1}, '{1'b1, 1'b0, 0, 1},
            '{1'b1, 1'b0, 0, 2}, '{1'b1, 1'b0, 0, 2}, '{1'b1, 1'b0, 0, 2}, '{1'b1, 1'b0, 0, 2},
            '{1'b0, 1'b0, 3, 0}, '{1'b0, 1'b0, 0, 1}, '{1'b1, 1'b0, 0, 1}, '{1'b1, 1'b0, 0, 1},
            '{1'b1, 1'b0, 0, 1}, '{1'b1, 1'b0, 1, 1}, '{1'b1, 1'b0, 0, 2}, '{1'b1, 1'b0, 0, 2},
            '{1'b1, 1'b0, 0, 2}, '{1'b1, 1'b0, 0, 2}, '{1'b0, 1'b1, 1, 0}, '{1'b0, 1'b0, 0, 1},
            '{1'b0, 1'b0, 0, 1}
        };

        reset = 1'b1; x = '0; y = '0;
        key_next = 1'b0; key_pause = 1'b0; auto_en = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk_reset_state("reset");
        reset = 1'b0;

        // Full-height frames, starting with a partial one that must not pulse.
        run_frame(100, 272, 0, 0, 0);
        chk("partial_frame_pulses", n_pulses, 0);
        repeat (3) run_frame(0, 272, 0, 0, 0);
        chk("frame_count_after_3", snap_fc, 3);
        chk("pulses_after_3", n_pulses, 3);

        // Auto-advance, key presses, co-timed key+timeout, key while paused.
        for (int k = 0; k < 25; k++) begin
            run_frame(0, FL, vecs[k].auto_on, vecs[k].pause, vecs[k].presses);
            chk($sformatf("vec%0d_scene", k), snap_scene, vecs[k].exp_scene);
        end

        // Right bound: 442 -> 444 (dir kept) -> 444 (dir flips) -> 442.
        guard = 0;
        while (!(m_sx == 442 && m_dx == 1) && guard < 600) begin
            run_frame(0, FL, 0, 0, 0);
            guard++;
        end
        chk("right_start_x", snap_sx, 442);
        run_frame(0, FL, 0, 0, 0);
        chk("right_exact_x", snap_sx, 444);  chk("right_exact_dir", snap_led[4], 1);
        run_frame(0, FL, 0, 0, 0);
        chk("right_flip_x", snap_sx, 444);   chk("right_flip_dir", snap_led[4], 0);
        run_frame(0, FL, 0, 0, 0);
        chk("right_back_x", snap_sx, 442);   chk("right_back_dir", snap_led[4], 0);

        // Left bound: 6 -> 4 (dir kept) -> 4 (dir flips) -> 6.
        guard = 0;
        while (!(m_sx == 6 && m_dx == 0) && guard < 600) begin
            run_frame(0, FL, 0, 0, 0);
            guard++;
        end
        chk("left_start_x", snap_sx, 6);
        run_frame(0, FL, 0, 0, 0);
        chk("left_exact_x", snap_sx, 4);     chk("left_exact_dir", snap_led[4], 0);
        run_frame(0, FL, 0, 0, 0);
        chk("left_flip_x", snap_sx, 4);      chk("left_flip_dir", snap_led[4], 1);
        run_frame(0, FL, 0, 0, 0);
        chk("left_back_x", snap_sx, 6);      chk("left_back_dir", snap_led[4], 1);

        // Pause with auto on: sprite and timer freeze, frame_count keeps counting.
        run_frame(0, FL, 1, 1, 0);
        held_sx = m_sx; held_dx = m_dx; held_fc = m_fc;
        for (int k = 1; k <= 10; k++) begin
            run_frame(0, FL, 1, 1, 0);
            chk("pause_sprite_x", snap_sx, held_sx);
            chk("pause_frame_count", snap_fc, held_fc + k);
            chk("pause_scene", snap_scene, 1);
        end
        run_frame(0, FL, 1, 0, 0);
        chk("release_still_held_x", snap_sx, held_sx);
        run_frame(0, FL, 1, 0, 0);
        chk("resume_x", snap_sx, held_sx + (held_dx != 0 ? 2 : -2));

        // Reach BARS, then reset in the middle of a frame.
        guard = 0;
        while (m_scene != 2 && guard < 8) begin
            run_frame(0, FL, 0, 0, (m_pending == 0) ? 1 : 0);
            guard++;
        end
        run_frame(0, FL, 0, 0, 0);
        chk("pre_reset_scene", snap_scene, 2);
        run_frame(0, 10, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("midframe_reset");
        model_reset();
        base_pulses = n_pulses;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        prev_y_m = 9;
        run_frame(10, FL, 0, 0, 0);
        chk("post_reset_no_pulse", n_pulses, base_pulses);
        run_frame(0, FL, 0, 0, 0);
        chk("post_reset_first_pulse", n_pulses, base_pulses + 1);
        chk("post_reset_frame_count", snap_fc, 1);

        repeat (4) @(posedge clock);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_scene_scheduler.md
Name: lcd_scene_scheduler

Overview:
Frame-synchronous controller that sequences the 480x272 LCD pixel renderer. It detects frame boundaries from the scanned pixel coordinates and selects the active scene via a small FSM (user key or auto-advance timer). It also animates a bouncing sprite. All renderer-facing outputs change only at frame start, so the combinational drawing logic never tears mid-frame.

Parameters:
SCREEN_W, 480, visible width in pixels
SCREEN_H, 272, visible height in pixels
BORDER, 4, frame thickness; sprite is confined inside it
SPRITE_W, 32, sprite width
SPRITE_H, 32, sprite height
STEP, 2, sprite pixels moved per frame per axis
AUTO_FRAMES, 300, frames per scene in auto mode (>=2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
x  in  9  current pixel x, 0..SCREEN_W-1
y  in  9  current pixel y, 0..SCREEN_H-1
key_next  in  1  raw button, level; rising edge advances the scene
key_pause  in  1  raw button, level; high freezes animation and auto timer
auto_en  in  1  enables auto-advance
frame_start  out  1  one-cycle pulse per detected frame
scene  out  2  active scene: 0 HELLO, 1 BOUNCE, 2 BARS
sprite_x  out  9  sprite left edge
sprite_y  out  9  sprite top edge
frame_count  out  16  frames since reset, wraps 65535->0
status_led  out  8  [1:0]=scene, [2]=paused, [3]=auto_en, [4]=dir_x, [5]=dir_y, [7:6]=0

Behaviour:
- Reset (async assert; release synchronous to clock):
  - frame_start=0, scene=0, frame_count=0.
  - sprite_x=BORDER, sprite_y=BORDER, dir_x=dir_y=+ (increasing).
  - Auto timer=0. Key synchronizers and edge detectors cleared. y_prev=0.
- Inputs: key_next and key_pause each pass through a 2-FF synchronizer. key_next rising edge = sync value 1 with previous sync value 0; this gives one event per press.
- Frame detect:
  - Register y_prev each cycle.
  - Wrap is defined as y < y_prev.
  - frame_start is registered: it is high for exactly one cycle, the cycle after the wrap sample.
  - No frame_start is issued until the first wrap after reset. A stalled y (no change) generates no pulses.
- Pending advance: a key_next edge sets a pending flag at any time. The flag is consumed at the next frame_start. Multiple presses within one frame produce a single advance.
- All state updates below occur on the clock edge ending the frame_start cycle, so new values are visible from the following cycle:
  - frame_count += 1.
  - Advance is taken if (pending) OR (auto_en AND !paused AND timer == AUTO_FRAMES-1).
    - When taken: scene = (scene==2) ? 0 : scene+1; timer=0; pending=0.
    - A key event coinciding with auto timeout causes a single advance only.
  - Otherwise, timer += 1 if auto_en and not paused. Timer holds when paused or when auto_en=0. Deasserting auto_en does not clear the timer.
  - Sprite motion happens only when scene==BOUNCE and not paused:
    - Bounds: xmax = SCREEN_W-BORDER-SPRITE_W (444), ymax = SCREEN_H-BORDER-SPRITE_H (236), min = BORDER (4).
    - Per axis, compute next = pos ± STEP. If next crosses a bound, pos = that bound and the direction flips; otherwise pos = next.
    - Arithmetic is 10-bit so decrements never underflow.
  - Entering BOUNCE from another scene does not reset the sprite; it resumes from its last position.
- paused = synced key_pause, sampled at frame_start only. It does not block scene advance by key.
- Outputs are held between frame_start pulses regardless of x/y or key activity.
- Reset mid-frame: all state returns to reset values; the first frame_start follows the next wrap.

Test Plan:
- Scan model stepping x 0..479, y 0..271, then wrap → frame_start high exactly 1 cycle after each y 271→0; frame_count=3 after 3 frames; no pulse during the first partial frame after reset.
- auto_en=1, AUTO_FRAMES=4 → scene goes 0→1 at the 4th frame_start, 1→2 at the 8th, 2→0 at the 12th.
- Three key_next presses within one frame, auto_en=0 → exactly one advance (0→1) at the next frame_start; key pulse co-timed with auto timeout → one advance, timer=0.
- scene=1, sprite_x=442, dir +, STEP=2 → next frame x=444 with dir unchanged (exactly at bound); then x=444 → x=444 with dir flipped to −; then x=442. Same check at x=4 going −.
- key_pause held, scene=1, auto_en=1 → sprite_x/y and timer frozen for 10 frames, frame_count still increments; release → motion resumes from the held value.
- Assert reset mid-frame while scene=2, sprite at (100,50) → immediately scene=0, sprite=(4,4), frame_count=0, frame_start=0; first frame_start follows the next wrap.
